// File: rtl/event_serializer.sv
// event_serializer
//   Buffers filtered DVS events in a small FIFO. Each event leaves as a
//   4-byte packet on an 8-bit valid/ready byte stream. The upstream filter
//   cannot be stalled, so an event that arrives while the FIFO is full is
//   dropped and counted.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid            an event is present this cycle
//   x_in, y_in, t_in    event coordinates and timestamp (8 bits each)
//   p_in                event polarity
//   dout, dout_valid    stream byte and its valid flag
//   dout_ready          the sink accepts the current byte
//   dout_last           the current byte is the last byte of its packet
//   level               FIFO occupancy, 0..DEPTH
//   overflow            sticky flag, set once any event has been dropped
//   drop_cnt            count of dropped events, saturates at 255
//
// Packet: {4'b1010,3'b000,p}, x, y, t (dout_last=1 on t)
//
// FSM states
//   state  | meaning
//   S_IDLE | nothing in flight, dout_valid=0; pops the head when FIFO non-empty
//   S_SEND | hold register being streamed, byte index idx_q on dout
module event_serializer #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    x_in,
  input  logic [7:0]    y_in,
  input  logic [7:0]    t_in,
  input  logic          p_in,
  output logic [7:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [24:0]   hold_q, hold_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [24:0]   mem_q [DEPTH];
  logic [24:0]   head;
  logic          fifo_nempty;
  logic          byte_acc;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // Entry layout {p, x, y, t}
  function automatic logic [7:0] pkt_byte(input logic [24:0] e, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = {4'b1010, 3'b000, e[24]};
      2'd1:    b = e[23:16];
      2'd2:    b = e[15:8];
      default: b = e[7:0];
    endcase
    return b;
  endfunction

  assign head        = mem_q[rd_ptr_q];
  assign fifo_nempty = (level_q != '0);
  assign byte_acc    = dout_valid_q && dout_ready;

  // State register (also holds the registered outputs and FIFO bookkeeping)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // FIFO storage carries no reset; contents are only read below level_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {p_in, x_in, y_in, t_in};
    end
  end

  // Next-state logic; pop happens only from IDLE or when byte3 is accepted.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (byte_acc && (idx_q == 2'd3)) begin
          if (fifo_nempty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. The next byte is computed one cycle ahead so
  // dout comes straight from a flop.
  always_comb begin
    idx_d        = idx_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;

    if (pop) begin
      hold_d       = head;
      idx_d        = 2'd0;
      dout_d       = pkt_byte(head, 2'd0);
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
    end else if (state_q == S_SEND && byte_acc) begin
      if (idx_q == 2'd3) begin
        idx_d        = 2'd0;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end else begin
        idx_d        = idx_q + 2'd1;
        dout_d       = pkt_byte(hold_q, idx_q + 2'd1);
        dout_last_d  = (idx_q == 2'd2);
      end
    end
  end

  // FIFO write/drop bookkeeping. A full FIFO still accepts an event when a
  // pop frees a slot on the same edge.
  always_comb begin
    wr_en      = in_valid && ((level_q != DEPTH_L) || pop);
    drop       = in_valid && !wr_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q || drop;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
